// File: rtl/div_pkg.sv
// Shared types and sizing helpers for the sequential signed divider.
package div_pkg;

  typedef enum logic [1:0] {IDLE, ITER, FIX, DONE} div_state_t;

  localparam int DIV_WIDTH_DEFAULT = 8;

  // Iteration counter must hold the value WIDTH itself.
  function automatic int cnt_width(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/div_step.sv
// One restoring shift-subtract iteration on unsigned magnitudes (combinational).
module div_step
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH_DEFAULT
) (
  input  logic [WIDTH:0]   a,
  input  logic [WIDTH-1:0] q,
  input  logic [WIDTH-1:0] m,
  output logic [WIDTH:0]   a_next,
  output logic [WIDTH-1:0] q_next
);

  logic [2*WIDTH:0] pair_shifted;
  logic [WIDTH:0]   a_shifted;
  logic [WIDTH:0]   trial;

  // A stays below M, so the partial remainder never needs its top bit after the shift.
  always_comb begin
    pair_shifted = {a, q} << 1;
    a_shifted    = pair_shifted[2*WIDTH:WIDTH];
    trial        = a_shifted - {1'b0, m};
    if (!trial[WIDTH]) begin
      a_next = trial;
      q_next = {pair_shifted[WIDTH-1:1], 1'b1};
    end else begin
      a_next = a_shifted;
      q_next = {pair_shifted[WIDTH-1:1], 1'b0};
    end
  end

endmodule

// File: rtl/signed_divider.sv
// Sequential signed divider: restoring division on magnitudes with sign fix-up.
// Handshake: start is taken only in IDLE; done pulses one cycle when results are valid.
module signed_divider
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] num_1,
  input  logic [WIDTH-1:0] num_2,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_zero,
  output logic             overflow,
  output div_state_t       state
);

  localparam int CW = cnt_width(WIDTH);
  localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  function automatic logic [WIDTH-1:0] negate(input logic [WIDTH-1:0] x);
    return (~x) + 1'b1;
  endfunction

  // Unsigned magnitude; the most negative value maps exactly to 2^(WIDTH-1).
  function automatic logic [WIDTH-1:0] abs_val(input logic [WIDTH-1:0] x);
    return x[WIDTH-1] ? negate(x) : x;
  endfunction

  div_state_t     state_next;
  logic [WIDTH:0]   a_reg;
  logic [WIDTH-1:0] q_reg;
  logic [WIDTH-1:0] m_reg;
  logic [CW-1:0]    cnt;
  logic             sign_q;
  logic             sign_r;
  logic             zero_pend;
  logic             ovf_pend;
  logic [WIDTH:0]   a_next;
  logic [WIDTH-1:0] q_next;

  div_step #(.WIDTH(WIDTH)) u_step (
    .a      (a_reg),
    .q      (q_reg),
    .m      (m_reg),
    .a_next (a_next),
    .q_next (q_next)
  );

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    busy       = 1'b0;
    case (state)
      IDLE: if (start) state_next = (num_2 == '0) ? FIX : ITER;
      ITER: begin
        busy = 1'b1;
        if (cnt == CW'(1)) state_next = FIX;
      end
      FIX: begin
        busy       = 1'b1;
        state_next = DONE;
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      a_reg     <= '0;
      q_reg     <= '0;
      m_reg     <= '0;
      cnt       <= '0;
      sign_q    <= 1'b0;
      sign_r    <= 1'b0;
      zero_pend <= 1'b0;
      ovf_pend  <= 1'b0;
      done      <= 1'b0;
      quotient  <= '0;
      remainder <= '0;
      div_zero  <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            a_reg     <= '0;
            q_reg     <= abs_val(num_1);
            m_reg     <= abs_val(num_2);
            sign_q    <= num_1[WIDTH-1] ^ num_2[WIDTH-1];
            sign_r    <= num_1[WIDTH-1];
            zero_pend <= (num_2 == '0);
            ovf_pend  <= (num_1 == MIN_NEG) && (num_2 == '1);
            div_zero  <= 1'b0;
            overflow  <= 1'b0;
            cnt       <= CW'(WIDTH);
          end
        end
        ITER: begin
          a_reg <= a_next;
          q_reg <= q_next;
          cnt   <= cnt - CW'(1);
        end
        FIX: begin
          done     <= 1'b1;
          div_zero <= zero_pend;
          overflow <= ovf_pend;
          // On divide-by-zero Q still holds |num_1|, so re-signing it returns the dividend.
          if (zero_pend) begin
            quotient  <= '0;
            remainder <= sign_r ? negate(q_reg) : q_reg;
          end else begin
            quotient  <= sign_q ? negate(q_reg) : q_reg;
            remainder <= sign_r ? negate(a_reg[WIDTH-1:0]) : a_reg[WIDTH-1:0];
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_signed_divider.sv
// Directed-vector and random-sample bench for signed_divider (WIDTH=8).
module tb_signed_divider;
  import div_pkg::*;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic [W-1:0] num_1;
  logic [W-1:0] num_2;
  logic         busy;
  logic         done;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         div_zero;
  logic         overflow;
  div_state_t   state;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  signed_divider #(.WIDTH(W)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .num_1     (num_1),
    .num_2     (num_2),
    .busy      (busy),
    .done      (done),
    .quotient  (quotient),
    .remainder (remainder),
    .div_zero  (div_zero),
    .overflow  (overflow),
    .state     (state)
  );

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         dz;
    logic         ov;
    int           lat;
  } vec_t;

  vec_t vecs[14];

  function automatic vec_t mk(input int a, input int b, input int q, input int r,
                              input logic dz, input logic ov, input int lat);
    vec_t v;
    v.a   = W'(a);
    v.b   = W'(b);
    v.q   = W'(q);
    v.r   = W'(r);
    v.dz  = dz;
    v.ov  = ov;
    v.lat = lat;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  // Entered and left #1 after a rising edge; start is driven in an IDLE cycle.
  task automatic run_div(input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [W-1:0] eq, input logic [W-1:0] er,
                         input logic edz, input logic eov, input int elat,
                         input int inject_at, input string tag);
    int   lat;
    logic seen;
    num_1 = a;
    num_2 = b;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    check({tag, "_busy"}, busy, 1);
    lat  = 0;
    seen = 1'b0;
    while (!seen && lat < 40) begin
      if (lat == inject_at) begin
        num_1 = 8'd1;
        num_2 = 8'd1;
        start = 1'b1;
      end
      @(posedge clk);
      #1;
      start = 1'b0;
      lat++;
      seen = done;
    end
    check({tag, "_latency"}, lat, elat);
    check({tag, "_quotient"}, quotient, eq);
    check({tag, "_remainder"}, remainder, er);
    check({tag, "_div_zero"}, div_zero, edz);
    check({tag, "_overflow"}, overflow, eov);
    @(posedge clk);
    #1;
    check({tag, "_done_width"}, done, 0);
  endtask

  task automatic model(input logic [W-1:0] a, input logic [W-1:0] b,
                       output logic [W-1:0] q, output logic [W-1:0] r,
                       output logic dz, output logic ov, output int lat);
    logic signed [W-1:0] sa;
    logic signed [W-1:0] sb;
    sa  = a;
    sb  = b;
    dz  = 1'b0;
    ov  = 1'b0;
    lat = 9;
    if (b == 0) begin
      q   = '0;
      r   = a;
      dz  = 1'b1;
      lat = 1;
    end else if (a == 8'h80 && b == 8'hff) begin
      q  = 8'h80;
      r  = '0;
      ov = 1'b1;
    end else begin
      q = W'(sa / sb);
      r = W'(sa % sb);
    end
  endtask

  initial begin
    logic [W-1:0] ra, rb, mq, mr;
    logic         mdz, mov;
    int           mlat;

    vecs[0]  = mk( 100,    7,   14,    2, 1'b0, 1'b0, 9);
    vecs[1]  = mk(-100,    7,  -14,   -2, 1'b0, 1'b0, 9);
    vecs[2]  = mk( 100,   -7,  -14,    2, 1'b0, 1'b0, 9);
    vecs[3]  = mk(-100,   -7,   14,   -2, 1'b0, 1'b0, 9);
    vecs[4]  = mk(-128,   -1, -128,    0, 1'b0, 1'b1, 9);
    vecs[5]  = mk(-128,    1, -128,    0, 1'b0, 1'b0, 9);
    vecs[6]  = mk(   5,    0,    0,    5, 1'b1, 1'b0, 1);
    vecs[7]  = mk(   9,    3,    3,    0, 1'b0, 1'b0, 9);
    vecs[8]  = mk( 127, -128,    0,  127, 1'b0, 1'b0, 9);
    vecs[9]  = mk(-128,    0,    0, -128, 1'b1, 1'b0, 1);
    vecs[10] = mk(   7,  100,    0,    7, 1'b0, 1'b0, 9);
    vecs[11] = mk(-128,  127,   -1,   -1, 1'b0, 1'b0, 9);
    vecs[12] = mk( 127,    1,  127,    0, 1'b0, 1'b0, 9);
    vecs[13] = mk(  -1,    1,   -1,    0, 1'b0, 1'b0, 9);

    reset = 1'b1;
    start = 1'b0;
    num_1 = '0;
    num_2 = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_state", state, IDLE);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_quotient", quotient, 0);
    check("rst_remainder", remainder, 0);
    check("rst_flags", {div_zero, overflow}, 0);
    reset = 1'b0;

    foreach (vecs[i])
      run_div(vecs[i].a, vecs[i].b, vecs[i].q, vecs[i].r, vecs[i].dz, vecs[i].ov,
              vecs[i].lat, -1, $sformatf("vec%0d", i));

    // Start mid-ITER must be ignored without disturbing the running division.
    run_div(8'd100, 8'd7, 8'd14, 8'd2, 1'b0, 1'b0, 9, 3, "ignore_start");

    // Reset on the 4th ITER edge aborts and clears every output.
    num_1 = 8'd100;
    num_2 = 8'd7;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    check("abort_state", state, IDLE);
    check("abort_busy_done", {busy, done}, 0);
    check("abort_quotient", quotient, 0);
    check("abort_remainder", remainder, 0);
    check("abort_flags", {div_zero, overflow}, 0);
    reset = 1'b0;
    run_div(8'd50, 8'd5, 8'd10, 8'd0, 1'b0, 1'b0, 9, -1, "after_abort");

    for (int n = 0; n < 300; n++) begin
      ra = W'($urandom_range(0, 255));
      case ($urandom_range(0, 9))
        0:       rb = 8'h00;
        1:       rb = 8'hff;
        2:       begin ra = 8'h80; rb = 8'hff; end
        default: rb = W'($urandom_range(0, 255));
      endcase
      model(ra, rb, mq, mr, mdz, mov, mlat);
      run_div(ra, rb, mq, mr, mdz, mov, mlat, -1, $sformatf("rand_%0h_%0h", ra, rb));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
